// File: rtl/sgb_packet_rx.sv
// SGB packet receiver: filters the GB joypad select lines, decodes 128-bit
// command packets and holds the last completed packet in a readable buffer.
module sgb_packet_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [1:0]  joy_p54,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        pkt_ready,
    input  logic        pkt_ack,
    output logic        overrun,
    output logic        rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_BIT, S_GAP, S_STOP, S_STOPGAP
    } state_t;

    localparam logic [1:0] SYM_RESET = 2'b00;
    localparam logic [1:0] SYM_BIT0  = 2'b10;
    localparam logic [1:0] SYM_BIT1  = 2'b01;
    localparam logic [1:0] SYM_HIGH  = 2'b11;

    state_t         r_state;
    logic [1:0]     r_samp;
    logic [1:0]     r_filt;
    logic [6:0]     r_cnt;
    logic [127:0]   r_sr;
    logic [127:0]   r_buf;
    logic           r_ready;
    logic           r_ovr;
    logic           w_data_sym;
    logic           w_commit;

    assign w_data_sym = (r_filt == SYM_BIT0) || (r_filt == SYM_BIT1);
    assign w_commit   = ce && (r_state == S_STOPGAP) && (r_filt == SYM_HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_samp  <= SYM_HIGH;
            r_filt  <= SYM_HIGH;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_buf   <= '0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (ce) begin
                // Two matching consecutive samples are needed before a symbol is accepted.
                r_samp <= joy_p54;
                if (joy_p54 == r_samp)
                    r_filt <= joy_p54;

                if (r_filt == SYM_RESET) begin
                    r_state <= S_SYNC;
                    r_cnt   <= '0;
                    r_sr    <= '0;
                end else begin
                    case (r_state)
                        S_SYNC:
                            if (r_filt == SYM_HIGH) r_state <= S_BIT;
                        S_BIT:
                            if (w_data_sym) begin
                                r_sr    <= {(r_filt == SYM_BIT1), r_sr[127:1]};
                                r_cnt   <= r_cnt + 7'd1;
                                r_state <= S_GAP;
                            end
                        S_GAP:
                            // Counter only reads zero here once all 128 bits have wrapped it.
                            if (r_filt == SYM_HIGH)
                                r_state <= (r_cnt == 7'd0) ? S_STOP : S_BIT;
                        S_STOP:
                            if (r_filt == SYM_BIT0) begin
                                r_state <= S_STOPGAP;
                            end else if (r_filt == SYM_BIT1) begin
                                r_sr    <= '0;
                                r_state <= S_IDLE;
                            end
                        S_STOPGAP:
                            if (r_filt == SYM_HIGH) r_state <= S_IDLE;
                        default:
                            r_state <= S_IDLE;
                    endcase
                end
            end

            // A commit wins over a simultaneous ack; the ack still clears overrun.
            if (w_commit)
                r_ready <= 1'b1;
            else if (pkt_ack)
                r_ready <= 1'b0;

            if (pkt_ack)
                r_ovr <= 1'b0;
            else if (w_commit && r_ready)
                r_ovr <= 1'b1;

            if (w_commit && !r_ready)
                r_buf <= r_sr;
        end
    end

    assign rd_data   = r_buf[{rd_addr, 3'b000} +: 8];
    assign pkt_ready = r_ready;
    assign overrun   = r_ovr;
    assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_sgb_packet_rx.sv
// Directed bench for sgb_packet_rx: drives joypad symbol sequences with
// hand-computed packet contents and checks flags and buffer bytes.
module tb_sgb_packet_rx;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [1:0]  joy_p54;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        pkt_ready;
    logic        pkt_ack;
    logic        overrun;
    logic        rx_busy;

    int n_cmp;
    int n_err;

    sgb_packet_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .joy_p54   (joy_p54),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pkt_ready (pkt_ready),
        .pkt_ack   (pkt_ack),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ce=1 clock followed by one ce=0 clock; inputs change #1 after edges.
    task automatic ce_pulse();
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic sym(input logic [1:0] s, input int n);
        joy_p54 = s;
        repeat (n) ce_pulse();
    endtask

    task automatic send_bit(input logic b);
        sym(b ? 2'b01 : 2'b10, 3);
        sym(2'b11, 3);
    endtask

    task automatic send_start();
        sym(2'b00, 3);
        sym(2'b11, 3);
    endtask

    // Full packet; optional glitch before bit glitch_at and ack in the commit cycle.
    task automatic send_packet(input logic [127:0] data, input logic stop_bit,
                               input int glitch_at, input logic ack_commit);
        send_start();
        for (int k = 0; k < 128; k++) begin
            if (k == glitch_at) begin
                joy_p54 = 2'b10;
                ce_pulse();
                sym(2'b11, 3);
                ce = 1'b0;
                joy_p54 = 2'b00;
                repeat (4) @(posedge clk);
                #1;
                joy_p54 = 2'b11;
            end
            send_bit(data[k]);
        end
        sym(stop_bit ? 2'b01 : 2'b10, 3);
        sym(2'b11, 2);
        joy_p54 = 2'b11;
        ce = 1'b1;
        pkt_ack = ack_commit;
        @(posedge clk); #1;
        ce = 1'b0;
        pkt_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic ack_pulse();
        pkt_ack = 1'b1;
        @(posedge clk); #1;
        pkt_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] mk_data(input logic [7:0] base, input logic [7:0] step);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = base + step * i[7:0];
        return d;
    endfunction

    task automatic chk_byte(input string name, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL %s rd_addr=%0h got %02h expected %02h", name, a, rd_data, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic e_rdy, input logic e_ovr, input logic e_busy);
        n_cmp++;
        if ({pkt_ready, overrun, rx_busy} !== {e_rdy, e_ovr, e_busy}) begin
            n_err++;
            $display("FAIL %s ready/ovr/busy got %b%b%b expected %b%b%b", name,
                     pkt_ready, overrun, rx_busy, e_rdy, e_ovr, e_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; joy_p54 = 2'b11; rd_addr = '0; pkt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_flags("reset_flags", 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) chk_byte("reset_buf", a[3:0], 8'h00);
    endtask

    task automatic test_valid();
        send_packet(mk_data(8'h00, 8'h01), 1'b0, -1, 1'b0);
        chk_flags("valid_flags", 1'b1, 1'b0, 1'b0);
        chk_byte("valid_b5", 4'h5, 8'h05);
        chk_byte("valid_bF", 4'hF, 8'h0F);
        chk_byte("valid_b0", 4'h0, 8'h00);
        ack_pulse();
        chk_flags("valid_ack", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_stop();
        send_start();
        send_bit(1'b1);
        chk_flags("badstop_busy", 1'b0, 1'b0, 1'b1);
        send_packet(mk_data(8'h30, 8'h01), 1'b1, -1, 1'b0);
        chk_flags("badstop_flags", 1'b0, 1'b0, 1'b0);
        chk_byte("badstop_b5", 4'h5, 8'h05);
        chk_byte("badstop_bF", 4'hF, 8'h0F);
    endtask

    task automatic test_mid_reset();
        logic [127:0] d;
        d = mk_data(8'h5A, 8'h13);
        send_start();
        for (int k = 0; k < 40; k++) send_bit(d[k]);
        send_packet({128{1'b1}}, 1'b0, -1, 1'b0);
        chk_flags("midrst_flags", 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) chk_byte("midrst_buf", a[3:0], 8'hFF);
    endtask

    task automatic test_overrun();
        send_packet({16{8'hAA}}, 1'b0, -1, 1'b0);
        chk_flags("ovr_flags", 1'b1, 1'b1, 1'b0);
        chk_byte("ovr_b3", 4'h3, 8'hFF);
        ack_pulse();
        chk_flags("ovr_ack", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        send_packet(mk_data(8'h10, 8'h01), 1'b0, 20, 1'b1);
        chk_flags("glitch_flags", 1'b1, 1'b0, 1'b0);
        chk_byte("glitch_b2", 4'h2, 8'h12);
        chk_byte("glitch_bF", 4'hF, 8'h1F);
        // Commit while ready with a simultaneous ack: packet dropped, overrun stays clear.
        send_packet({16{8'hAA}}, 1'b0, -1, 1'b1);
        chk_flags("drop_ack_flags", 1'b1, 1'b0, 1'b0);
        chk_byte("drop_ack_b2", 4'h2, 8'h12);
    endtask

    task automatic test_async_reset();
        logic [127:0] d;
        d = mk_data(8'h77, 8'h05);
        send_start();
        for (int k = 0; k < 64; k++) send_bit(d[k]);
        chk_flags("arst_pre", 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_flags("arst_flags", 1'b0, 1'b0, 1'b0);
        chk_byte("arst_b2", 4'h2, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_packet(mk_data(8'hC0, 8'h01), 1'b0, -1, 1'b0);
        chk_flags("arst_post_flags", 1'b1, 1'b0, 1'b0);
        chk_byte("arst_post_b0", 4'h0, 8'hC0);
        chk_byte("arst_post_b9", 4'h9, 8'hC9);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_valid();
        test_bad_stop();
        test_mid_reset();
        test_overrun();
        test_glitch();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sgb_packet_rx.md
SGB_PACKET_RX -- requirements
Module: sgb_packet_rx

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ce  input  1  GB clock enable; joypad lines are sampled only in cycles with ce=1.
REQ-004 SHALL have port joy_p54  input  2  GB joypad select lines from the GB core; bit0=P14, bit1=P15; 0 = line driven low.
REQ-005 SHALL have port rd_addr  input  4  byte index into the completed-packet buffer.
REQ-006 SHALL have port rd_data  output  8  buffer byte at rd_addr, combinational.
REQ-007 SHALL have port pkt_ready  output  1  a completed packet is held in the buffer.
REQ-008 SHALL have port pkt_ack  input  1  single-cycle pulse from the register side that clears pkt_ready.
REQ-009 SHALL have port overrun  output  1  sticky; a packet completed while pkt_ready=1; cleared by pkt_ack.
REQ-010 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL filter the input: the filtered value is updated only when the same joy_p54 value is sampled on 2 consecutive ce cycles.
REQ-012 SHALL decode filtered symbols as follows: 00 = RESET, 10 = bit 0 (P14 low), 01 = bit 1 (P15 low), 11 = IDLE-HIGH.
REQ-013 SHALL use the states IDLE, SYNC, BIT, GAP, STOP and STOPGAP.
REQ-014 SHALL leave IDLE only on RESET, going to SYNC with bit counter = 0.
REQ-015 SHALL, in SYNC, go to BIT on 11; a data symbol in SYNC is ignored.
REQ-016 SHALL, in BIT, go to GAP on a data symbol: shift the bit into a 128-bit shift register, LSB first within each byte, byte 0 first, and increment the 7-bit counter.
REQ-017 SHALL, in GAP, wait for 11 and then go to BIT, or to STOP if the counter wrapped (128 bits received).
REQ-018 SHALL, in STOP, treat a bit-0 symbol as a valid stop bit and go to STOPGAP.
REQ-019 SHALL, in STOP, treat a bit-1 symbol as a framing error: discard the shift register and go to IDLE with no flag change.
REQ-020 SHALL, on 11 in STOPGAP, commit and go to IDLE; commit copies the shift register to the output buffer and sets pkt_ready the next clk.
REQ-021 SHALL, if pkt_ready=1 at commit, drop the new packet (buffer unchanged) and set overrun.
REQ-022 SHALL restart from SYNC with counter = 0 on RESET in any state other than IDLE; a partial packet is discarded.
REQ-023 SHALL let a commit take priority over pkt_ack in the same cycle: pkt_ready stays 1.
REQ-024 SHALL, in that same cycle, still clear overrun via pkt_ack, and the drop of REQ-021 still applies.
REQ-025 SHALL hold the output buffer stable while pkt_ready=1.
REQ-026 SHALL ignore all joy_p54 activity in cycles with ce=0; state is held.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear: state=IDLE, counter=0, filter value=11, shift register=0, buffer=0, pkt_ready=0, overrun=0, rx_busy=0.
REQ-028 SHALL drive rd_data=00 for every rd_addr after reset.

Verification
REQ-029 SHALL cover a valid packet: RESET, then 128 bits encoding bytes 00..0F, stop 0, 11 -> pkt_ready=1; rd_addr=5 gives 05; rd_addr=F gives 0F.
REQ-030 SHALL cover a bad stop bit: the same packet with stop=1 -> pkt_ready stays 0, buffer unchanged, state IDLE.
REQ-031 SHALL cover a mid-packet RESET: RESET after 40 bits, then a full packet of all-FF bytes -> buffer all FF, pkt_ready=1.
REQ-032 SHALL cover overrun: a second valid packet (bytes AA) without pkt_ack -> overrun=1, buffer still holds the first packet; pkt_ack -> pkt_ready=0, overrun=0.
REQ-033 SHALL cover glitch rejection: a single-ce 10 pulse between 11 samples -> no bit counted; pkt_ack in the commit cycle -> pkt_ready=1.
REQ-034 SHALL cover reset mid-reception: rst_n low after 64 bits -> all outputs 0 immediately; the next full packet is received correctly.
